uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

UART receive front end: oversampling bit sampler, frame state machine and deserializer. It sits directly upstream of the receive parity checker. It drives that checker's data, sampled bit and check-enable inputs, and consumes its registered error result. It delivers an 8-bit frame with a one-cycle valid pulse to the register/synchronizer stage downstream.

## Interface
Parameters:
- DATA_WIDTH, 8, payload bits per frame (LSB first).

Ports:
- CLK  in  1  receive oversampling clock.
- RST  in  1  reset, asynchronous, active-low; clock CLK.
- RX_IN  in  1  serial line, already synchronized to CLK; idle high.
- Prescale  in  6  oversampling ratio. 16 and 32 are honoured; any other value is treated as 8. Latched at frame start.
- PAR_EN  in  1  parity bit present in frame. Latched at frame start.
- par_err  in  1  registered result from the parity checker.
- sampled_bit  out  1  voted bit value for the current bit period.
- par_chk_en  out  1  one-cycle strobe to the parity checker.
- P_DATA  out  DATA_WIDTH  deserialized payload.
- data_valid  out  1  one-cycle pulse when a clean frame completes.
- stp_err  out  1  stop-bit error flag for the last frame.
- busy  out  1  high while not in IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Let P be the effective Prescale and h = P/2.
- edge_cnt counts 0..P-1 per bit period. bit_cnt counts 0..DATA_WIDTH-1 in DATA.
- IDLE, RX_IN==0:
  - go to START with edge_cnt=1, so the detect cycle counts as edge 0.
  - latch P and PAR_EN.
  - clear stp_err and the internal parity-error flag.
- Sampling: RX_IN is captured at edge_cnt h-1, h and h+1. sampled_bit is set to the 2-of-3 majority on the clock ending edge h+1. It is therefore valid during edges h+2..P-1 and holds until the next update.
- All bit decisions are made on the clock ending edge_cnt==P-1.
- START:
  - sampled_bit==1 is a glitch: go to IDLE, no flags set.
  - otherwise go to DATA with bit_cnt=0.
- DATA:
  - P_DATA[bit_cnt] <= sampled_bit.
  - after bit DATA_WIDTH-1, go to PARITY if PAR_EN is latched, else to STOP.
- PARITY:
  - par_chk_en is high for exactly the edge_cnt==P-2 cycle.
  - par_err is valid during edge P-1. It is latched into an internal flag at the end of that cycle. The checker clears par_err afterwards, so this latch is mandatory.
  - go to STOP.
- STOP:
  - sampled_bit==0 sets stp_err.
  - data_valid pulses on the next cycle only if the stop bit is good and the parity flag is clear.
  - go to IDLE.
- P_DATA is stable from the end of the last DATA bit until the next frame's first DATA write. It is written only in DATA.
- Prescale and PAR_EN changes mid-frame are ignored.
- RX_IN low in the cycle after STOP evaluation starts a new frame. Back-to-back frames are therefore supported.

## Timing
- All outputs reset to 0: sampled_bit, par_chk_en, P_DATA, data_valid, stp_err, busy. State resets to IDLE and both counters reset to 0.
- Asynchronous reset mid-frame aborts immediately. No data_valid is produced for the aborted frame.
- Frame with detect at cycle t0 and N = 10 + PAR_EN bits: STOP is evaluated at the end of cycle t0+N·P-1, and data_valid is high in cycle t0+N·P.
- stp_err updates in the same cycle data_valid would occur. It holds until the next START entry.
- busy is high from t0+1 through the STOP evaluation cycle.
- par_chk_en is never asserted outside PARITY.

## Configuration
- UART_RX_MAJORITY_EN:
  - defined: 3-sample majority vote as above.
  - undefined: a single sample at edge h, registered on the clock ending edge h. sampled_bit then becomes valid from edge h+1.
- All downstream timing (par_chk_en at P-2, decisions at P-1) is identical in both builds.

## Test plan
- P=8, PAR_EN=1, even parity, byte 0xA5 with parity 0, stop 1, detect at t0 -> par_chk_en pulses once at t0+9·8+6. data_valid is high exactly at t0+88, P_DATA=0xA5, stp_err=0.
- P=16, PAR_EN=0, byte 0x3C -> data_valid at t0+160, P_DATA=0x3C. par_chk_en is never asserted.
- P=8, start bit low for only 2 cycles, then high -> return to IDLE after 8 cycles. No data_valid and no stp_err; busy falls.
- P=8, PAR_EN=1, checker returns par_err=1 -> no data_valid, stp_err=0, P_DATA still holds the received byte.
- P=32, stop bit driven 0 -> stp_err=1 at t0+11·32, no data_valid. A following good frame clears stp_err on its START entry.
- P=8, RST asserted in DATA after 3 bits, released, then a full frame 0x81 -> all outputs are 0 during reset, and the next frame delivers 0x81 normally.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// UART receive front end: oversampling bit sampler, frame state machine and
// LSB-first deserializer. Feeds the downstream parity checker and captures
// its registered result. Presents each clean frame with a one-cycle
// data_valid pulse.
//
// Build option:
//   UART_RX_MAJORITY_EN  defined   -> 2-of-3 vote of samples at edges h-1,h,h+1
//                        undefined -> single sample at edge h
//
// Ports:
//   CLK          receive oversampling clock
//   RST          asynchronous active-low reset
//   RX_IN        serial line (already synchronized, idle high)
//   Prescale     oversampling ratio; 16 or 32, anything else means 8
//   PAR_EN       parity bit present in frame
//   par_err      registered result from the parity checker
//   sampled_bit  voted/sampled value of the current bit period
//   par_chk_en   one-cycle strobe to the parity checker
//   P_DATA       deserialized payload
//   data_valid   one-cycle pulse on a clean frame
//   stp_err      stop-bit error of the last frame
//   busy         high while a frame is in progress
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line idle, waiting for a falling start edge
// START  | start bit period; sampled high at its end means a glitch
// DATA   | DATA_WIDTH payload bits, LSB first
// PARITY | parity bit; strobe checker at edge P-2, latch result at P-1
// STOP   | stop bit; flag error or deliver the frame
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  par_err,
    output logic                  sampled_bit,
    output logic                  par_chk_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [5:0]     edge_cnt;
    logic [5:0]     p_lat;
    logic [5:0]     p_sel;
    logic [5:0]     p_last;
    logic [5:0]     half;
    logic [BCW-1:0] bit_cnt;
    logic           par_en_lat;
    logic           par_flag;
    logic           start_det;
    logic           bit_end;
    logic           last_data_bit;

    always_comb begin
        p_sel = 6'd8;
        if (Prescale == 6'd16) begin
            p_sel = 6'd16;
        end else if (Prescale == 6'd32) begin
            p_sel = 6'd32;
        end
    end

    assign p_last        = p_lat - 6'd1;
    assign half          = {1'b0, p_lat[5:1]};
    assign bit_end       = (state != IDLE) && (edge_cnt == p_last);
    assign last_data_bit = (bit_cnt == BCW'(DATA_WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_det  = 1'b0;
        par_chk_en = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    start_det = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && last_data_bit) begin
                    state_nxt = par_en_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_chk_en = (edge_cnt == (p_last - 6'd1));
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, frame configuration and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt   <= 6'd0;
            bit_cnt    <= '0;
            p_lat      <= 6'd8;
            par_en_lat <= 1'b0;
            par_flag   <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            // The detect cycle itself is edge 0, so START begins at edge 1.
            if (state == IDLE) begin
                edge_cnt <= start_det ? 6'd1 : 6'd0;
            end else if (bit_end) begin
                edge_cnt <= 6'd0;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end

            if (start_det) begin
                p_lat      <= p_sel;
                par_en_lat <= PAR_EN;
                stp_err    <= 1'b0;
                par_flag   <= 1'b0;
            end

            case (state)
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        P_DATA[bit_cnt] <= sampled_bit;
                        bit_cnt         <= bit_cnt + BCW'(1);
                    end
                end
                PARITY: begin
                    // Checker drops par_err after one cycle, so keep it here.
                    if (bit_end) begin
                        par_flag <= par_err;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        stp_err    <= ~sampled_bit;
                        data_valid <= sampled_bit & ~par_flag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bit sampler
    // ------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
    logic s_lo;
    logic s_mid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_lo        <= 1'b0;
            s_mid       <= 1'b0;
            sampled_bit <= 1'b0;
        end else if (state != IDLE) begin
            if (edge_cnt == (half - 6'd1)) begin
                s_lo <= RX_IN;
            end
            if (edge_cnt == half) begin
                s_mid <= RX_IN;
            end
            // Third sample is taken live and voted in the same cycle.
            if (edge_cnt == (half + 6'd1)) begin
                sampled_bit <= (s_lo & s_mid) | (s_lo & RX_IN) | (s_mid & RX_IN);
            end
        end
    end
`else
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sampled_bit <= 1'b0;
        end else if ((state != IDLE) && (edge_cnt == half)) begin
            sampled_bit <= RX_IN;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       par_err;
    logic       sampled_bit;
    logic       par_chk_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       stp_err;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [7:0] cur_data = 8'h00;
    logic       cur_par  = 1'b0;

    int         dv_cyc[$];
    logic [7:0] dv_data[$];
    logic       dv_stp[$];
    int         pc_cyc[$];
    int         br_cyc[$];
    logic       br_stp[$];
    int         bf_cyc[$];
    logic       busy_q = 1'b0;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .par_err     (par_err),
        .sampled_bit (sampled_bit),
        .par_chk_en  (par_chk_en),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Parity checker model: even parity, result registered for one cycle.
    always @(posedge CLK or negedge RST) begin
        if (!RST) par_err <= 1'b0;
        else      par_err <= par_chk_en & ((^cur_data) ^ cur_par);
    end

    // Event recorder, sampled mid-cycle.
    always @(negedge CLK) begin
        if (data_valid) begin
            dv_cyc.push_back(cyc);
            dv_data.push_back(P_DATA);
            dv_stp.push_back(stp_err);
        end
        if (par_chk_en) pc_cyc.push_back(cyc);
        if (busy && !busy_q) begin
            br_cyc.push_back(cyc);
            br_stp.push_back(stp_err);
        end
        if (!busy && busy_q) bf_cyc.push_back(cyc);
        busy_q = busy;
    end

    function automatic int eff_p(input logic [5:0] pres);
        if (pres == 6'd16) return 16;
        if (pres == 6'd32) return 32;
        return 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        dv_cyc.delete(); dv_data.delete(); dv_stp.delete();
        pc_cyc.delete(); br_cyc.delete(); br_stp.delete(); bf_cyc.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [5:0] pres, input logic pen,
                              input logic bad_par, input logic stop_v, output int t0);
        int p;
        logic pb;
        p  = eff_p(pres);
        pb = (^d) ^ bad_par;
        clear_q();
        cur_data = d;
        cur_par  = pb;
        @(negedge CLK);
        Prescale = pres;
        PAR_EN   = pen;
        RX_IN    = 1'b0;
        t0       = cyc;
        repeat (p) @(negedge CLK);
        // Configuration changes mid-frame must be ignored.
        Prescale = 6'($urandom_range(0, 63));
        PAR_EN   = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (p) @(negedge CLK);
        end
        if (pen) begin
            RX_IN = pb;
            repeat (p) @(negedge CLK);
        end
        RX_IN = stop_v;
        repeat (p) @(negedge CLK);
        RX_IN = 1'b1;
    endtask

    task automatic check_frame(input logic [7:0] d, input logic [5:0] pres, input logic pen,
                               input logic bad_par, input logic stop_v, input int t0);
        int p;
        int n;
        int good;
        p    = eff_p(pres);
        n    = 10 + int'(pen);
        good = (stop_v && !bad_par) ? 1 : 0;
        repeat (3) @(negedge CLK);
        check("dv_count", dv_cyc.size(), good);
        if (dv_cyc.size() > 0 && good == 1) begin
            check("dv_cycle", dv_cyc[0], t0 + n * p);
            check("dv_data", dv_data[0], d);
            check("dv_stp_err", dv_stp[0], 0);
        end
        check("p_data_hold", P_DATA, d);
        check("stp_err", stp_err, !stop_v);
        check("par_chk_count", pc_cyc.size(), pen);
        if (pc_cyc.size() > 0)
            check("par_chk_cycle", pc_cyc[0], t0 + 9 * p + p - 2);
        check("busy_rise_count", br_cyc.size(), 1);
        if (br_cyc.size() > 0) begin
            check("busy_rise_cycle", br_cyc[0], t0 + 1);
            check("stp_err_cleared_at_start", br_stp[0], 0);
        end
        check("busy_fall_count", bf_cyc.size(), 1);
        if (bf_cyc.size() > 0)
            check("busy_fall_cycle", bf_cyc[0], t0 + n * p);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int t0;
        int sel;
        logic [7:0] d;
        logic [5:0] pres;
        logic pen, bad, stp;

        RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {sampled_bit, par_chk_en, P_DATA, data_valid, stp_err, busy}, 0);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        // P=8 with even parity, byte A5.
        send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b1, t0);
        check_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b1, t0);

        // P=16, no parity, byte 3C.
        send_frame(8'h3C, 6'd16, 1'b0, 1'b0, 1'b1, t0);
        check_frame(8'h3C, 6'd16, 1'b0, 1'b0, 1'b1, t0);

        // Start glitch: low for only 2 cycles at P=8.
        clear_q();
        @(negedge CLK);
        Prescale = 6'd8; PAR_EN = 1'b0; RX_IN = 1'b0; t0 = cyc;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (12) @(negedge CLK);
        check("glitch_dv_count", dv_cyc.size(), 0);
        check("glitch_stp_err", stp_err, 0);
        check("glitch_busy_fall_count", bf_cyc.size(), 1);
        if (bf_cyc.size() > 0) check("glitch_busy_fall_cycle", bf_cyc[0], t0 + 8);
        check("glitch_busy", busy, 0);
        check("glitch_p_data_kept", P_DATA, 8'h3C);

        // Parity error reported by the checker.
        send_frame(8'h5E, 6'd8, 1'b1, 1'b1, 1'b1, t0);
        check_frame(8'h5E, 6'd8, 1'b1, 1'b1, 1'b1, t0);

        // P=32, stop bit low.
        send_frame(8'hC3, 6'd32, 1'b1, 1'b0, 1'b0, t0);
        check_frame(8'hC3, 6'd32, 1'b1, 1'b0, 1'b0, t0);

        // Following good frame clears stp_err.
        send_frame(8'h17, 6'd8, 1'b0, 1'b0, 1'b1, t0);
        check_frame(8'h17, 6'd8, 1'b0, 1'b0, 1'b1, t0);

        // Reset in DATA after 3 bits of 0x81.
        clear_q();
        cur_data = 8'h81; cur_par = 1'b0;
        @(negedge CLK);
        Prescale = 6'd8; PAR_EN = 1'b0; RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1; repeat (8) @(negedge CLK);
        RX_IN = 1'b0; repeat (8) @(negedge CLK);
        RX_IN = 1'b0; repeat (8) @(negedge CLK);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("reset_mid_frame_outputs", {sampled_bit, par_chk_en, P_DATA, data_valid, stp_err, busy}, 0);
        repeat (3) @(negedge CLK);
        check("reset_held_outputs", {sampled_bit, par_chk_en, P_DATA, data_valid, stp_err, busy}, 0);
        RX_IN = 1'b1;
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        check("reset_no_dv", dv_cyc.size(), 0);
        send_frame(8'h81, 6'd8, 1'b0, 1'b0, 1'b1, t0);
        check_frame(8'h81, 6'd8, 1'b0, 1'b0, 1'b1, t0);

        // Randomized frames.
        for (int k = 0; k < 10; k++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       pres = 6'd16;
                1:       pres = 6'd32;
                2:       pres = 6'd8;
                default: pres = 6'($urandom_range(0, 63));
            endcase
            d   = 8'($urandom_range(0, 255));
            pen = 1'($urandom_range(0, 1));
            bad = pen && ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 4) != 0);
            send_frame(d, pres, pen, bad, stp, t0);
            check_frame(d, pres, pen, bad, stp, t0);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
